// File: rtl/deque_pkg.sv
// Shared opcode, state and sizing definitions for the deque sequencer and
// the two deques it drives.
package deque_pkg;

   localparam int DEPTH_DEFAULT = 16;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_PUSH  = 3'd1;
   localparam logic [2:0] OP_POP   = 3'd2;
   localparam logic [2:0] OP_PEEK  = 3'd3;
   localparam logic [2:0] OP_MOVE  = 3'd4;
   localparam logic [2:0] OP_DUP   = 3'd5;
   localparam logic [2:0] OP_SWAP  = 3'd6;
   localparam logic [2:0] OP_CLEAR = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRIME0 = 3'd1,
      ST_READ0  = 3'd2,
      ST_PRIME1 = 3'd3,
      ST_READ1  = 3'd4,
      ST_WRITE  = 3'd5,
      ST_CLEAR  = 3'd6,
      ST_DONE   = 3'd7
   } state_t;

endpackage

// File: rtl/deque_sequencer.sv
// Command sequencer driving two attached deques through one shared
// select/push/pop port; one command in flight, one-cycle completion pulse.
module deque_sequencer
   import deque_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic       cmd_sel,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       deque_select,
   output logic       push,
   output logic       pop,
   output logic [7:0] data_in,
   input  logic       empty0,
   input  logic       empty1,
   input  logic       full0,
   input  logic       full1,
   input  logic [7:0] top0,
   input  logic [7:0] top1
);

   if (DEPTH < 1) begin : g_depth_chk
      $error("deque_sequencer: DEPTH must be at least 1");
   end

   state_t     state;
   logic [2:0] op_q;
   logic       sel_q;
   logic [7:0] a_q;

   logic       e_sel, e_oth, f_sel, f_oth, pre_fail;
   logic [7:0] top_sel, top_oth;

   assign e_sel   = sel_q ? empty1 : empty0;
   assign e_oth   = sel_q ? empty0 : empty1;
   assign f_sel   = sel_q ? full1  : full0;
   assign f_oth   = sel_q ? full0  : full1;
   assign top_sel = sel_q ? top1   : top0;
   assign top_oth = sel_q ? top0   : top1;

   // Every op that reaches PRIME0 reads the source, so it must be non-empty.
   assign pre_fail = e_sel
                   | ((op_q == OP_MOVE) & f_oth)
                   | ((op_q == OP_DUP)  & f_sel)
                   | ((op_q == OP_SWAP) & e_oth);

   assign cmd_ready = (state == ST_IDLE);

   // Strobes follow the current state and flags so CLEAR stops on the
   // exact cycle the deque reports empty, without an overshoot pop.
   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      unique case (state)
         ST_READ0: pop = (op_q == OP_POP) | (op_q == OP_MOVE);
         ST_READ1: begin
            push = 1'b1;
            pop  = 1'b1;
         end
         ST_WRITE: begin
            push = (op_q == OP_PUSH) ? ~f_sel : 1'b1;
            pop  = (op_q == OP_SWAP);
         end
         ST_CLEAR: pop = ~e_sel;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         op_q         <= OP_NOP;
         sel_q        <= 1'b0;
         a_q          <= 8'h00;
         deque_select <= 1'b0;
         data_in      <= 8'h00;
         rsp_valid    <= 1'b0;
         rsp_data     <= 8'h00;
         rsp_err      <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            ST_IDLE: if (cmd_valid) begin
               op_q  <= cmd_op;
               sel_q <= cmd_sel;
               unique case (cmd_op)
                  OP_NOP: begin
                     state     <= ST_DONE;
                     rsp_valid <= 1'b1;
                     rsp_data  <= 8'h00;
                     rsp_err   <= 1'b0;
                  end
                  OP_PUSH: begin
                     state        <= ST_WRITE;
                     deque_select <= cmd_sel;
                     data_in      <= cmd_data;
                  end
                  OP_CLEAR: begin
                     state        <= ST_CLEAR;
                     deque_select <= cmd_sel;
                  end
                  default: begin
                     state        <= ST_PRIME0;
                     deque_select <= cmd_sel;
                  end
               endcase
            end
            ST_PRIME0: begin
               if (pre_fail) begin
                  state     <= ST_DONE;
                  rsp_valid <= 1'b1;
                  rsp_data  <= 8'h00;
                  rsp_err   <= 1'b1;
               end else begin
                  state <= ST_READ0;
               end
            end
            ST_READ0: begin
               a_q <= top_sel;
               unique case (op_q)
                  OP_MOVE, OP_DUP: begin
                     state        <= ST_WRITE;
                     deque_select <= (op_q == OP_MOVE) ? ~sel_q : sel_q;
                     data_in      <= top_sel;
                  end
                  OP_SWAP: begin
                     state        <= ST_PRIME1;
                     deque_select <= ~sel_q;
                  end
                  default: begin
                     state     <= ST_DONE;
                     rsp_valid <= 1'b1;
                     rsp_data  <= top_sel;
                     rsp_err   <= 1'b0;
                  end
               endcase
            end
            ST_PRIME1: begin
               state   <= ST_READ1;
               data_in <= a_q;
            end
            // Other deque's top is replaced with A here; B goes back to sel next.
            ST_READ1: begin
               state        <= ST_WRITE;
               deque_select <= sel_q;
               data_in      <= top_oth;
            end
            ST_WRITE: begin
               state     <= ST_DONE;
               rsp_valid <= 1'b1;
               if (op_q == OP_PUSH) begin
                  rsp_data <= 8'h00;
                  rsp_err  <= f_sel;
               end else begin
                  rsp_data <= a_q;
                  rsp_err  <= 1'b0;
               end
            end
            ST_CLEAR: if (e_sel) begin
               state     <= ST_DONE;
               rsp_valid <= 1'b1;
               rsp_data  <= 8'h00;
               rsp_err   <= 1'b0;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/deque_sequencer.md
DEQUE_SEQUENCER -- requirements
Module: deque_sequencer

Interface
REQ-001 The block SHALL have the following parameter: DEPTH, default 16, words per attached deque; used only for documentation and checks.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, sequencer can accept a command.
- cmd_op, in, 3, opcode.
- cmd_sel, in, 1, source deque (0/1).
- cmd_data, in, 8, immediate for PUSH.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_data, out, 8, value read (POP/PEEK/MOVE/DUP; SWAP returns the old top of sel).
- rsp_err, out, 1, command rejected; no deque modified.
- deque_select, out, 1, deque addressed this cycle.
- push, out, 1, push strobe to the selected deque.
- pop, out, 1, pop strobe to the selected deque.
- data_in, out, 8, push data.
- empty0/empty1, in, 1 each, deque empty flags.
- full0/full1, in, 1 each, deque full flags.
- top0/top1, in, 8 each, deque top words; valid only if that deque was selected in the previous cycle.

Function
REQ-003 The opcodes SHALL be: 0 NOP, 1 PUSH, 2 POP, 3 PEEK, 4 MOVE (sel to other), 5 DUP, 6 SWAP (exchange the tops of both deques), 7 CLEAR.
REQ-004 The FSM states SHALL be IDLE, PRIME0, READ0, PRIME1, READ1, WRITE, CLEAR, DONE.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready, and all cmd fields are registered at acceptance (cycle 0).
REQ-006 push and pop SHALL be 0 in every state not listed below; deque_select holds its last value outside active states.
REQ-007 NOP SHALL go IDLE -> DONE, with rsp_valid in cycle 1.
REQ-008 PUSH SHALL, in cycle 1, select sel and push cmd_data if the sel deque is not full, else set err; rsp_valid in cycle 2.
REQ-009 POP/PEEK SHALL use PRIME0 (cycle 1: select sel, no strobe) then READ0 (cycle 2: capture top into rsp_data; pop=1 for POP only), with rsp_valid in cycle 3.
REQ-010 MOVE SHALL run PRIME0, then READ0 (pop sel, capture), then WRITE (cycle 3: select other, push the captured word), with rsp_valid in cycle 4.
REQ-011 DUP SHALL follow the MOVE sequence, except WRITE pushes to sel.
REQ-012 SWAP SHALL run the following sequence, with rsp_valid in cycle 6:
- PRIME0 (cycle 1): select sel.
- READ0 (cycle 2): capture A.
- PRIME1 (cycle 3): select other.
- READ1 (cycle 4): capture B; push=pop=1 with data A (top replace).
- WRITE (cycle 5): select sel; push=pop=1 with data B.
REQ-013 CLEAR SHALL, each cycle in CLEAR, select sel and assert pop=1 while empty_sel=0; on empty_sel=1 go to DONE. For N stored words, rsp_valid arrives in cycle N+2.
REQ-014 Preconditions SHALL be checked in PRIME0 from the flags:
- POP/PEEK/MOVE/DUP/SWAP: source not empty.
- MOVE: other not full.
- DUP: sel not full.
- SWAP: other not empty.
REQ-015 On a failed precondition, the block SHALL go to DONE with rsp_err=1 and rsp_data=0, rsp_valid in cycle 2, and issue no strobes.
REQ-016 DONE SHALL last exactly one cycle (rsp_valid=1) and then return to IDLE; back-to-back commands are therefore separated by at least one IDLE cycle.
REQ-017 rsp_data and rsp_err SHALL hold their values until the next DONE.

Reset
REQ-018 rst_n=0 at a clock edge SHALL force IDLE, with cmd_ready=1, push=pop=0, deque_select=0, data_in=0, rsp_valid=0, rsp_err=0, rsp_data=0, and captured registers cleared.
REQ-019 Reset mid-command SHALL abort the command with no further strobes and no rsp_valid pulse.

Structure
REQ-020 The opcode localparams, state encoding and DEPTH default SHALL reside in the shared package deque_pkg.
REQ-021 The block SHALL be a single module with no sub-modules; the parent instantiates two deques (ADDR 0 and 1) beside it.

Verification
REQ-022 After reset, PUSH 0x11 then PUSH 0x22 to sel0 -> rsp_valid each with err=0; PEEK sel0 -> rsp_data=0x22 in cycle 3.
REQ-023 POP on an empty deque1 -> rsp_err=1, rsp_data=0, rsp_valid in cycle 2, pop never asserted.
REQ-024 deque0 holds {0x11,0x22}, deque1 holds {0x33}; SWAP sel0 -> deque0 top=0x33, deque1 top=0x22, rsp_data=0x22, rsp_valid in cycle 6.
REQ-025 16 PUSHes to deque1, then PUSH 0x55 -> err=1; then DUP sel1 -> err=1; then MOVE sel0 (deque0 non-empty) -> err=1, and both deques are unchanged.
REQ-026 CLEAR sel0 with 3 words -> exactly 3 pop cycles, empty0=1, rsp_valid in cycle 5.
REQ-027 Assert rst_n=0 during READ1 of a SWAP -> no strobes after the reset edge, no rsp_valid, and cmd_ready=1 the next cycle.
